// File: rtl/dpram_arbiter.sv
`default_nettype none
// ============================================================================
// dpram_arbiter : round-robin sequencer for the raminfr shared write/read port.
// Optional RAMARB_INIT_EN : zero-fill the whole RAM after reset (busy high).
// Revision      : 1.0
// ============================================================================
module dpram_arbiter #(
  parameter int AW = 5,
  parameter int DW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          rvalid0,
  output logic          rvalid1,
  output logic [DW-1:0] rdata0,
  output logic [DW-1:0] rdata1,
  output logic          ram_we,
  output logic [AW-1:0] ram_a,
  output logic [DW-1:0] ram_di,
  input  logic [DW-1:0] ram_spo,
  output logic          busy
);

  typedef enum logic [1:0] {
    S_INIT = 2'd0,
    S_IDLE = 2'd1,
    S_ACC  = 2'd2,
    S_RESP = 2'd3
  } state_t;

`ifdef RAMARB_INIT_EN
  localparam state_t c_reset_state = S_INIT;
`else
  localparam state_t c_reset_state = S_IDLE;
`endif

  state_t r_state;
  logic   r_last;
  logic   r_win;
  logic   r_we;

  logic   w_any;
  logic   w_sel1;

  // On a tie the requester that was not served last wins.
  assign w_any  = req0 | req1;
  assign w_sel1 = req1 & (~req0 | ~r_last);

`ifndef RAMARB_INIT_EN
  assign busy = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_reset_state;
      r_last  <= 1'b1;
      r_win   <= 1'b0;
      r_we    <= 1'b0;
      gnt0    <= 1'b0;
      gnt1    <= 1'b0;
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      rdata0  <= '0;
      rdata1  <= '0;
      ram_we  <= 1'b0;
      ram_a   <= '0;
      ram_di  <= '0;
`ifdef RAMARB_INIT_EN
      busy    <= 1'b0;
`endif
    end else begin
      gnt0    <= 1'b0;
      gnt1    <= 1'b0;
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      case (r_state)
`ifdef RAMARB_INIT_EN
        // ram_a doubles as the fill counter; the first INIT edge arms the fill.
        S_INIT: begin
          if (!busy) begin
            busy   <= 1'b1;
            ram_we <= 1'b1;
            ram_a  <= '0;
            ram_di <= '0;
          end else if (ram_a == {AW{1'b1}}) begin
            busy    <= 1'b0;
            ram_we  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            ram_a <= ram_a + 1'b1;
          end
        end
`endif
        S_IDLE: begin
          if (w_any) begin
            r_win   <= w_sel1;
            r_last  <= w_sel1;
            r_we    <= w_sel1 ? we1 : we0;
            gnt0    <= ~w_sel1;
            gnt1    <= w_sel1;
            ram_we  <= w_sel1 ? we1 : we0;
            ram_a   <= w_sel1 ? addr1 : addr0;
            ram_di  <= w_sel1 ? wdata1 : wdata0;
            r_state <= S_ACC;
          end
        end
        S_ACC: begin
          ram_we  <= 1'b0;
          r_state <= S_RESP;
        end
        S_RESP: begin
          if (!r_we) begin
            if (r_win) begin
              rdata1  <= ram_spo;
              rvalid1 <= 1'b1;
            end else begin
              rdata0  <= ram_spo;
              rvalid0 <= 1'b1;
            end
          end
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dpram_arbiter.sv
`default_nettype none
// tb_dpram_arbiter: scoreboard bench for dpram_arbiter driving a behavioural raminfr model.
module tb_dpram_arbiter;
  localparam int AW    = 5;
  localparam int DW    = 4;
  localparam int DEPTH = 1 << AW;

  logic          clk    = 1'b0;
  logic          rst_n  = 1'b0;
  logic          req0   = 1'b0;
  logic          req1   = 1'b0;
  logic          we0    = 1'b0;
  logic          we1    = 1'b0;
  logic [AW-1:0] addr0  = '0;
  logic [AW-1:0] addr1  = '0;
  logic [DW-1:0] wdata0 = '0;
  logic [DW-1:0] wdata1 = '0;
  logic          gnt0, gnt1, rvalid0, rvalid1, ram_we, busy;
  logic [DW-1:0] rdata0, rdata1, ram_di, ram_spo;
  logic [AW-1:0] ram_a;

  typedef struct packed {
    logic          id;
    logic [DW-1:0] data;
  } rd_t;

  logic [DW-1:0] mem   [DEPTH];
  logic [DW-1:0] model [DEPTH];
  rd_t  exp_q[$];
  int   vectors = 0;
  int   errors  = 0;
  int   cyc     = 0;
  int   n_gnt0 = 0, n_gnt1 = 0, n_rv = 0, n_we = 0;
  logic last_model = 1'b1;

  dpram_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1),
    .ram_we(ram_we), .ram_a(ram_a), .ram_di(ram_di), .ram_spo(ram_spo),
    .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // raminfr write/read port: synchronous write, asynchronous read
  always @(posedge clk) if (ram_we) mem[ram_a] <= ram_di;
  assign ram_spo = mem[ram_a];

  always @(negedge clk) begin
    n_gnt0 <= n_gnt0 + (gnt0 ? 1 : 0);
    n_gnt1 <= n_gnt1 + (gnt1 ? 1 : 0);
    n_rv   <= n_rv + ((rvalid0 | rvalid1) ? 1 : 0);
    n_we   <= n_we + (ram_we ? 1 : 0);
  end

  // Drives one request, waits (bounded) for its grant and records the expectation.
  task automatic issue(input logic id, input logic we, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, output int gcyc);
    rd_t e;
    gcyc = -1;
    if (id) begin req1 = 1'b1; we1 = we; addr1 = a; wdata1 = d; end
    else    begin req0 = 1'b1; we0 = we; addr0 = a; wdata0 = d; end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if ((id ? gnt1 : gnt0) === 1'b1) begin gcyc = cyc; break; end
    end
    if (id) req1 = 1'b0; else req0 = 1'b0;
    if (gcyc >= 0) begin
      last_model = id;
      if (we) model[a] = d;
      else begin e.id = id; e.data = model[a]; exp_q.push_back(e); end
    end
  endtask

  task automatic wait_rv(output logic id, output logic [DW-1:0] data, output int rcyc);
    rcyc = -1; id = 1'b0; data = '0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rvalid0 === 1'b1 || rvalid1 === 1'b1) begin
        id = rvalid1; data = rvalid1 ? rdata1 : rdata0; rcyc = cyc; break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    vectors++;
    if ({gnt0, gnt1, rvalid0, rvalid1, ram_we, busy} !== 6'b0) begin
      errors++; $display("FAIL reset_ctl got %b want 000000", {gnt0, gnt1, rvalid0, rvalid1, ram_we, busy});
    end
    vectors++;
    if ({rdata0, rdata1, ram_a, ram_di} !== '0) begin
      errors++; $display("FAIL reset_data got %h want 0", {rdata0, rdata1, ram_a, ram_di});
    end
    @(negedge clk);
    rst_n = 1'b1; last_model = 1'b1;
`ifndef RAMARB_INIT_EN
    repeat (2) @(negedge clk);
    vectors++;
    if ({busy, ram_we, gnt0, gnt1} !== 4'b0) begin
      errors++; $display("FAIL reset_idle got %b want 0000", {busy, ram_we, gnt0, gnt1});
    end
`endif
  endtask

`ifdef RAMARB_INIT_EN
  task automatic test_init_fill();
    int   busy_cyc = 0, gnt_in = 0, bad = 0, gcyc, rcyc;
    logic seen = 1'b0, rid;
    logic [DW-1:0] rd;
    rd_t  e;
    req0 = 1'b1; we0 = 1'b0; addr0 = 5'd31;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (busy === 1'b1) begin
        seen = 1'b1; busy_cyc++;
        if (gnt0 | gnt1) gnt_in++;
        if (!(ram_we === 1'b1 && ram_a === AW'(busy_cyc - 1) && ram_di === '0)) bad++;
      end else if (seen) break;
    end
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
    vectors++;
    if (busy_cyc != 32) begin errors++; $display("FAIL init_busy got %0d want 32", busy_cyc); end
    vectors++;
    if (gnt_in != 0 || bad != 0) begin
      errors++; $display("FAIL init_fill got gnt=%0d badwrites=%0d want 0/0", gnt_in, bad);
    end
    issue(1'b0, 1'b0, 5'd31, '0, gcyc);
    wait_rv(rid, rd, rcyc);
    vectors++;
    if (gcyc < 0 || rcyc < 0 || exp_q.size() == 0) begin
      errors++; $display("FAIL init_read got gnt=%0d rvalid=%0d want both", gcyc, rcyc);
    end else begin
      e = exp_q.pop_front();
      if ({rid, rd} !== e) begin errors++; $display("FAIL init_read got %h want %h", {rid, rd}, e); end
    end
  endtask
`endif

  task automatic test_write_read();
    int   g1, g2, r, s_g1, s_rv, s_we;
    logic rid;
    logic [DW-1:0] rd;
    rd_t  e;
    #1; s_g1 = n_gnt1; s_rv = n_rv; s_we = n_we;
    issue(1'b0, 1'b1, 5'd5, 4'hA, g1);
    vectors++;
    if (!(g1 >= 0 && ram_we === 1'b1 && ram_a === 5'd5 && ram_di === 4'hA)) begin
      errors++; $display("FAIL wr_access got gnt=%0d we=%b a=%0d di=%h want we=1 a=5 di=a", g1, ram_we, ram_a, ram_di);
    end
    @(negedge clk);
    vectors++;
    if (ram_we !== 1'b0 || gnt0 !== 1'b0) begin
      errors++; $display("FAIL wr_pulse got we=%b gnt0=%b want 0/0", ram_we, gnt0);
    end
    issue(1'b0, 1'b0, 5'd5, '0, g2);
    wait_rv(rid, rd, r);
    vectors++;
    if (g2 < 0 || r < 0 || r - g2 != 2) begin
      errors++; $display("FAIL rd_latency got gnt=%0d rvalid=%0d want 2 edges apart", g2, r);
    end
    vectors++;
    if (exp_q.size() == 0) begin errors++; $display("FAIL rd_data got no expectation want one"); end
    else begin
      e = exp_q.pop_front();
      if ({rid, rd} !== e) begin errors++; $display("FAIL rd_data got %h want %h", {rid, rd}, e); end
    end
    #1;
    vectors++;
    if (n_gnt1 != s_g1 || n_rv - s_rv != 1 || n_we - s_we != 1) begin
      errors++; $display("FAIL wr_rd_side got gnt1=%0d rv=%0d we=%0d want 0/1/1", n_gnt1 - s_g1, n_rv - s_rv, n_we - s_we);
    end
  endtask

  task automatic test_back_to_back();
    int g[3];
    issue(1'b0, 1'b1, 5'd1, 4'h4, g[0]);
    issue(1'b0, 1'b1, 5'd2, 4'h7, g[1]);
    issue(1'b0, 1'b1, 5'd7, 4'h6, g[2]);
    vectors++;
    if (g[0] < 0 || g[1] - g[0] != 3 || g[2] - g[1] != 3) begin
      errors++; $display("FAIL b2b_spacing got %0d %0d %0d want 3-cycle spacing", g[0], g[1], g[2]);
    end
  endtask

  task automatic test_lone_requester();
    int   g[4], gr, r, s_g0;
    logic rid;
    logic [DW-1:0] rd;
    rd_t  e;
    #1; s_g0 = n_gnt0;
    for (int i = 0; i < 4; i++) issue(1'b1, 1'b1, AW'(28 + i), DW'(12 + i), g[i]);
    for (int i = 1; i < 4; i++) begin
      vectors++;
      if (g[i - 1] < 0 || g[i] - g[i - 1] != 3) begin
        errors++; $display("FAIL lone_spacing[%0d] got %0d want 3", i, g[i] - g[i - 1]);
      end
    end
    for (int i = 0; i < 4; i++) begin
      issue(1'b1, 1'b0, AW'(28 + i), '0, gr);
      wait_rv(rid, rd, r);
      vectors++;
      if (gr < 0 || r < 0 || exp_q.size() == 0) begin
        errors++; $display("FAIL lone_read[%0d] got gnt=%0d rvalid=%0d want both", i, gr, r);
      end else begin
        e = exp_q.pop_front();
        if ({rid, rd} !== e) begin errors++; $display("FAIL lone_read[%0d] got %h want %h", i, {rid, rd}, e); end
      end
    end
    #1;
    vectors++;
    if (n_gnt0 != s_g0) begin errors++; $display("FAIL lone_gnt0 got %0d want 0", n_gnt0 - s_g0); end
  endtask

  task automatic test_tie_alternate();
    logic exp_id = ~last_model;
    int   ng = 0, nr = 0, prev = -1;
    rd_t  e, o;
    req0 = 1'b1; we0 = 1'b0; addr0 = 5'd1;
    req1 = 1'b1; we1 = 1'b0; addr1 = 5'd2;
    for (int i = 0; i < 40 && !(ng == 4 && exp_q.size() == 0); i++) begin
      @(negedge clk);
      if (rvalid0 === 1'b1 || rvalid1 === 1'b1) begin
        o.id = rvalid1; o.data = rvalid1 ? rdata1 : rdata0; nr++;
        vectors++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL tie_read got %h want none", o); end
        else begin
          e = exp_q.pop_front();
          if (o !== e) begin errors++; $display("FAIL tie_read got %h want %h", o, e); end
        end
      end
      if (gnt0 === 1'b1 || gnt1 === 1'b1) begin
        vectors++;
        if ({gnt1, gnt0} !== (exp_id ? 2'b10 : 2'b01) || (prev >= 0 && cyc - prev != 3)) begin
          errors++; $display("FAIL tie_order[%0d] got gnt=%b gap=%0d want gnt=%b gap=3", ng, {gnt1, gnt0}, cyc - prev, exp_id ? 2'b10 : 2'b01);
        end
        e.id = exp_id; e.data = model[exp_id ? 2 : 1];
        exp_q.push_back(e);
        last_model = exp_id; exp_id = ~exp_id; prev = cyc; ng++;
        if (ng == 4) begin req0 = 1'b0; req1 = 1'b0; end
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    vectors++;
    if (ng != 4 || nr != 4) begin errors++; $display("FAIL tie_count got gnt=%0d rvalid=%0d want 4/4", ng, nr); end
  endtask

  task automatic test_reset_mid();
    int   got = 0, rvs = 0, gr, r;
    logic first_busy = 1'b0, rid;
    logic [DW-1:0] rd;
    rd_t  e;
    req0 = 1'b1; we0 = 1'b1; addr0 = 5'd7; wdata0 = 4'h3;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (gnt0 === 1'b1) begin got = 1; break; end
    end
    rst_n = 1'b0; req0 = 1'b0;
    #1;
    vectors++;
    if (got == 0 || {gnt0, gnt1, rvalid0, rvalid1, ram_we, busy, rdata0, rdata1, ram_a, ram_di} !== '0) begin
      errors++; $display("FAIL rst_mid_outputs got gnt_seen=%0d out=%h want 1/0", got,
                         {gnt0, gnt1, rvalid0, rvalid1, ram_we, busy, rdata0, rdata1, ram_a, ram_di});
    end
    @(negedge clk);
    rst_n = 1'b1; last_model = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (i == 0) first_busy = busy;
      if (rvalid0 | rvalid1 | gnt0 | gnt1) rvs++;
      if (i >= 3 && !busy) break;
    end
`ifdef RAMARB_INIT_EN
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
    vectors++;
    if (first_busy !== 1'b1) begin errors++; $display("FAIL rst_mid_state got busy=%b want 1", first_busy); end
`else
    vectors++;
    if (first_busy !== 1'b0) begin errors++; $display("FAIL rst_mid_state got busy=%b want 0", first_busy); end
`endif
    vectors++;
    if (rvs != 0) begin errors++; $display("FAIL rst_mid_quiet got %0d events want 0", rvs); end
    issue(1'b0, 1'b0, 5'd7, '0, gr);
    wait_rv(rid, rd, r);
    vectors++;
    if (gr < 0 || r < 0 || exp_q.size() == 0) begin
      errors++; $display("FAIL rst_mid_read got gnt=%0d rvalid=%0d want both", gr, r);
    end else begin
      e = exp_q.pop_front();
      if ({rid, rd} !== e) begin errors++; $display("FAIL rst_mid_read got %h want %h", {rid, rd}, e); end
    end
  endtask

  initial begin
    test_reset();
`ifdef RAMARB_INIT_EN
    test_init_fill();
`endif
    test_write_read();
    test_back_to_back();
    test_lone_requester();
    test_tie_alternate();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
